// File: rtl/stopwatch_pkg.sv
// Shared definitions for the minutes:seconds stopwatch: state encoding, field
// limits and two-digit BCD helpers.
package stopwatch_pkg;

  localparam int DIGIT_W     = 4;
  localparam int MIN_MAX_DEF = 59;
  localparam int SEC_MAX_DEF = 59;

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd2_t;

  function automatic logic bcd2_at_max(bcd2_t v, int max);
    return (v.tens == DIGIT_W'(max / 10)) && (v.ones == DIGIT_W'(max % 10));
  endfunction

  // Wraps to 00 at max; never carries out, the caller decides that.
  function automatic bcd2_t bcd2_inc(bcd2_t v, int max);
    bcd2_t r;
    r = v;
    if (bcd2_at_max(v, max)) begin
      r = '0;
    end else if (v.ones == DIGIT_W'(9)) begin
      r.tens = v.tens + DIGIT_W'(1);
      r.ones = '0;
    end else begin
      r.ones = v.ones + DIGIT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_rise_detect.sv
// Registered rising-edge detector: samples a slow level once, then flags the
// cycle in which the sampled value goes 0 -> 1.
module rise_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    sync_d = din;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/stopwatch_core.sv
// Minutes:seconds BCD stopwatch with run/pause and a 2 Hz field-adjust mode.
// The divider square waves are treated purely as sampled levels.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int MIN_MAX = MIN_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_in,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       adj_active
);

  logic rise_1hz, rise_2hz, rise_pause;

  rise_detect u_rise_1hz   (.clk_in(clk_in), .rst(rst), .din(tick_1hz), .rise(rise_1hz));
  rise_detect u_rise_2hz   (.clk_in(clk_in), .rst(rst), .din(tick_2hz), .rise(rise_2hz));
  rise_detect u_rise_pause (.clk_in(clk_in), .rst(rst), .din(pause_in), .rise(rise_pause));

  state_e state_q, state_d;
  bcd2_t  min_q, min_d;
  bcd2_t  sec_q, sec_d;
  logic   adj_q, adj_d;
  logic   sel_q, sel_d;

  // Counting decisions use the registered adj/sel and the pre-toggle state, so a
  // coincident pause rise only affects the next tick.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    adj_d   = adj;
    sel_d   = sel;

    if (rise_pause) begin
      state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end

    if (adj_q) begin
      if (rise_2hz) begin
        if (sel_q) begin
          sec_d = bcd2_inc(sec_q, SEC_MAX);
        end else begin
          min_d = bcd2_inc(min_q, MIN_MAX);
        end
      end
    end else if ((state_q == ST_RUN) && rise_1hz) begin
      sec_d = bcd2_inc(sec_q, SEC_MAX);
      if (bcd2_at_max(sec_q, SEC_MAX)) begin
        min_d = bcd2_inc(min_q, MIN_MAX);
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= ST_PAUSED;
      min_q   <= '0;
      sec_q   <= '0;
      adj_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      adj_q   <= adj_d;
      sel_q   <= sel_d;
    end
  end

  assign min_tens   = min_q.tens;
  assign min_ones   = min_q.ones;
  assign sec_tens   = sec_q.tens;
  assign sec_ones   = sec_q.ones;
  assign running    = (state_q == ST_RUN);
  assign adj_active = adj_q;

endmodule
